dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core. Serves the MEM-stage load/store requests (`mem_read`/`mem_write`) with a configurable number of wait states.
- Holds the pipeline through a stall signal until each access completes.
- Sits between the datapath MEM stage and the word-addressed data store, which lives inside this block.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the data store (power of two, ≥ 4).
- WAIT_CYCLES, 2, wait states between request acceptance and access commit (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read  input  1  MEM-stage load request (level, held by pipeline while stalled).
- mem_write  input  1  MEM-stage store request (level, held by pipeline while stalled).
- addr  input  32  byte address from ALU result.
- wdata  input  32  store data.
- rdata  output  32  load data; valid when ready=1 and err=0, held until the next successful load.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready; the access was rejected.
- stall  output  1  freeze PC/IF/ID/EX/MEM pipeline registers.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rdata=0, ready=0, err=0, wait counter=0, latched request cleared.
  - stall=0 while rst=1.
  - Store contents are not cleared.
- States:
  - IDLE: if mem_read|mem_write, latch op/addr/wdata at the edge. If the request is illegal, go to RESP with err. Otherwise, if WAIT_CYCLES=0, commit the access at that edge and go to RESP; else load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement counter each cycle. At counter=0, commit the access at the edge and go to RESP.
  - RESP: ready=1 for exactly one cycle, err as computed; unconditionally go to IDLE next edge. Request inputs are ignored in RESP; they still belong to the completing instruction.
- Commit:
  - Store writes mem[addr[log2(DEPTH_WORDS)+1:2]] = latched wdata.
  - Load registers rdata from the same index.
  - Commit happens only on the edge into RESP.
- stall (combinational) = (IDLE & (mem_read|mem_write) & ~rst) | WAIT. It is 0 in RESP, so the pipeline advances on the RESP edge.
- Latency: a request first seen in cycle T completes with ready in cycle T+WAIT_CYCLES+1. Stall cycles = WAIT_CYCLES+1.
- Illegal request (err=1, no commit, rdata unchanged, still goes through RESP after 0 wait states):
  - mem_read & mem_write both 1;
  - addr[1:0] != 0;
  - addr[31:2] >= DEPTH_WORDS.
- Latched values are used throughout WAIT. Input changes during WAIT are ignored.
- Back-to-back: a new request presented in the cycle after RESP is accepted normally. There is no idle bubble requirement beyond RESP itself.
- Reset mid-operation (WAIT): request aborted, no store committed, ready never pulses.
- Address wrap: none. Out-of-range addresses are errors, not aliased.
- No request: block stays in IDLE with ready=0, stall=0, and rdata holding its value.

Test Plan:
- Reset → rdata=0, ready=0, err=0, stall=0. Apply rst asynchronously mid-cycle → outputs clear before the next edge.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 at cycle T → stall=1 in T..T+2, ready=1 err=0 at T+3. Then load 0x10 → rdata=0xDEADBEEF at ready.
- WAIT_CYCLES=0: load of 0x10 → stall=1 for one cycle, ready the next cycle. Back-to-back store 0x14=0x12345678 then load 0x14 in consecutive requests → 0x12345678, with no lost or duplicated ready.
- Illegal requests, each → ready=1 err=1 one cycle after the request, no memory change, rdata unchanged:
  - load from 0x13 (misaligned);
  - store to 0x400 with DEPTH_WORDS=256 (out of range);
  - mem_read=mem_write=1.
- Store to 0x20 with rst pulsed during WAIT → no ready. A subsequent load 0x20 returns the prior contents, not the aborted data.
- Change addr/wdata during WAIT of a store to 0x08 → the originally latched values are written to 0x08.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data store with configurable wait states and pipeline stall
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic op_wr, err_q, req, legal, commit, c_wr;
  logic [AW-1:0] idx, c_idx;
  logic [31:0] wd, c_wd;
  logic [31:0] mem [DEPTH_WORDS];
  assign req   = mem_read | mem_write;
  assign legal = ~(mem_read & mem_write) && addr[1:0] == 2'b00 && addr[31:2] < 30'(DEPTH_WORDS);
  assign c_wr  = state == IDLE ? mem_write : op_wr;
  assign c_idx = state == IDLE ? addr[AW+1:2] : idx;
  assign c_wd  = state == IDLE ? wdata : wd;
  assign ready = state == RESP;
  assign err   = ready & err_q;
  assign stall = (state == IDLE && req && !rst) || state == WAIT;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (!legal) state_n = RESP;
        else if (WAIT_CYCLES == 0) begin
          commit  = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n   = 4'(WAIT_CYCLES - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd0) begin
          commit  = 1'b1;
          state_n = RESP;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_wr <= 1'b0;
      idx   <= '0;
      wd    <= '0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        op_wr <= mem_write;
        idx   <= addr[AW+1:2];
        wd    <= wdata;
        err_q <= ~legal;
      end
      if (commit && !c_wr) rdata <= mem[c_idx];
    end
  end
  always_ff @(posedge clk) begin
    if (commit && c_wr && !rst) mem[c_idx] <= c_wd;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of wait-state timing, errors, reset abort and latching
module tb_dmem_responder;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata2, rdata0, o_rdata;
  logic ready2, ready0, err2, err0, stall2, stall0, o_ready, o_err, o_stall;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .mem_read(rd & sel), .mem_write(wr & sel), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .err(err2), .stall(stall2));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd & ~sel), .mem_write(wr & ~sel), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0), .stall(stall0));
  assign o_rdata = sel ? rdata2 : rdata0;
  assign o_ready = sel ? ready2 : ready0;
  assign o_err   = sel ? err2 : err0;
  assign o_stall = sel ? stall2 : stall0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic acc(input string tag, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic e, input logic [31:0] exp_rd, input logic mangle);
    int nw;
    nw = e ? 0 : (sel ? 2 : 0);
    rd = r; wr = w; addr = a; wdata = d;
    for (int i = 0; i <= nw; i++) begin
      @(negedge clk);
      chk({tag, ".stall"}, 32'(o_stall), 32'd1);
      chk({tag, ".noready"}, 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      if (mangle && i == 0) begin
        addr = 32'h0C; wdata = 32'h55555555;
      end
    end
    @(negedge clk);
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".err"}, 32'(o_err), 32'(e));
    chk({tag, ".respstall"}, 32'(o_stall), 32'd0);
    chk({tag, ".rdata"}, o_rdata, exp_rd);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask
  initial begin
    @(posedge clk); #1;
    rd = 1'b1;
    @(negedge clk);
    chk("rst.stall2", 32'(stall2), 32'd0);
    chk("rst.stall0", 32'(stall0), 32'd0);
    chk("rst.rdata", rdata2, 32'd0);
    chk("rst.ready", 32'(ready2), 32'd0);
    chk("rst.err", 32'(err2), 32'd0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acc("st10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
    acc("ld10", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    acc("st20", 0, 1, 32'h20, 32'h11111111, 0, 32'hDEADBEEF, 0);
    acc("st0c", 0, 1, 32'h0C, 32'hCAFEF00D, 0, 32'hDEADBEEF, 0);
    acc("st08m", 0, 1, 32'h08, 32'h08080808, 0, 32'hDEADBEEF, 1);
    acc("ld08", 1, 0, 32'h08, 32'h0, 0, 32'h08080808, 0);
    acc("ld0c", 1, 0, 32'h0C, 32'h0, 0, 32'hCAFEF00D, 0);
    acc("mis13", 1, 0, 32'h13, 32'h0, 1, 32'hCAFEF00D, 0);
    acc("oor400", 0, 1, 32'h400, 32'hFFFFFFFF, 1, 32'hCAFEF00D, 0);
    acc("rdwr10", 1, 1, 32'h10, 32'h0, 1, 32'hCAFEF00D, 0);
    acc("ld10b", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
    wr = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort.waitstall", 32'(o_stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort.stall", 32'(o_stall), 32'd0);
    chk("abort.rdata", o_rdata, 32'd0);
    chk("abort.ready", 32'(o_ready), 32'd0);
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort.noready", 32'(o_ready), 32'd0);
    end
    @(posedge clk); #1;
    acc("ld20", 1, 0, 32'h20, 32'h0, 0, 32'h11111111, 0);
    sel = 1'b0;
    acc("z.st14", 0, 1, 32'h14, 32'h12345678, 0, 32'h0, 0);
    acc("z.ld14", 1, 0, 32'h14, 32'h0, 0, 32'h12345678, 0);
    acc("z.st10", 0, 1, 32'h10, 32'h0F0F0F0F, 0, 32'h12345678, 0);
    acc("z.ld10", 1, 0, 32'h10, 32'h0, 0, 32'h0F0F0F0F, 0);
    acc("z.mis13", 1, 0, 32'h13, 32'h0, 1, 32'h0F0F0F0F, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("z.idle.ready", 32'(o_ready), 32'd0);
      chk("z.idle.stall", 32'(o_stall), 32'd0);
      chk("z.idle.rdata", o_rdata, 32'h0F0F0F0F);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
